// File: rtl/soft_gamma.sv
// soft_gamma: two-stage pipelined IDS-channel branch metric (gamma) for drift-based BCJR.
module soft_gamma #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 16,
  parameter int PROB_W     = 16,
  parameter int P_D        = 21845,
  parameter int P_I        = 21845,
  parameter int P_S        = 21845,
  parameter int I_MAX      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IDX_W-1:0]      N,
  input  logic [DATA_WIDTH-1:0] r,
  input  logic [IDX_W-1:0]      t,
  input  logic [IDX_W-1:0]      d,
  input  logic [IDX_W-1:0]      d_tag,
  input  logic                  b,
  output logic                  out_valid,
  output logic [PROB_W:0]       gamma_out
);
  localparam int RW = $clog2(DATA_WIDTH);
  localparam int MW = (I_MAX > 0) ? $clog2(I_MAX + 1) : 1;
  localparam int SW = IDX_W + 2;
  localparam int PPW = 2 * PROB_W + 2;
  localparam logic [PROB_W:0] ONE = (PROB_W + 1)'(1) << PROB_W;
  localparam logic [PROB_W:0] PT = ONE - (PROB_W + 1)'(P_D) - (PROB_W + 1)'(P_I);
  localparam logic [PROB_W:0] E_HIT = ONE - (PROB_W + 1)'(P_S);
  localparam logic [PROB_W:0] E_MISS = (PROB_W + 1)'(P_S);
  localparam logic [PROB_W:0] P_IH = (PROB_W + 1)'(P_I >> 1);
  localparam logic [IDX_W-1:0] DW = IDX_W'(DATA_WIDTH);
  localparam logic signed [SW-1:0] DEL = '1;
  localparam logic signed [SW-1:0] IMX = SW'(I_MAX);
  logic signed [SW-1:0] p, delta, q, n_s;
  logic [IDX_W-1:0] n_c;
  logic [PROB_W:0] e, g1_d, g1_q, g2, gamma_d, gamma_q;
  logic [PPW-1:0] prod, prod2;
  logic [MW-1:0] m1_d, m1_q;
  logic v1_q, ov_q, del_ok, sub_ok;
  // p and drift difference are kept two bits wider than the index so t+d never wraps
  always_comb begin
    n_c = (N > DW) ? DW : N;
    n_s = SW'(n_c);
    p = SW'(t) + {{2{d[IDX_W-1]}}, d};
    delta = {{2{d_tag[IDX_W-1]}}, d_tag} - {{2{d[IDX_W-1]}}, d};
    q = p + delta;
    e = (r[q[RW-1:0]] == b) ? E_HIT : E_MISS;
    prod = PPW'(PT) * PPW'(e);
    del_ok = (delta == DEL) && !p[SW-1] && (p <= n_s);
    sub_ok = !delta[SW-1] && (delta <= IMX) && !p[SW-1] && (q < n_s);
    g1_d = del_ok ? (PROB_W + 1)'(P_D) : sub_ok ? (PROB_W + 1)'(prod >> PROB_W) : '0;
    m1_d = sub_ok ? delta[MW-1:0] : '0;
  end
  // each inserted bit scales by P_I/2; unrolled to I_MAX stages, enabled by m
  always_comb begin
    g2 = g1_q;
    prod2 = '0;
    for (int i = 0; i < I_MAX; i++) begin
      prod2 = PPW'(g2) * PPW'(P_IH);
      g2 = (MW'(i) < m1_q) ? (PROB_W + 1)'(prod2 >> PROB_W) : g2;
    end
    gamma_d = (g2 > ONE) ? ONE : g2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      g1_q <= '0;
      m1_q <= '0;
      ov_q <= 1'b0;
      gamma_q <= '0;
    end else begin
      v1_q <= in_valid;
      ov_q <= v1_q;
      if (in_valid) begin
        g1_q <= g1_d;
        m1_q <= m1_d;
      end
      if (v1_q) gamma_q <= gamma_d;
    end
  assign out_valid = ov_q;
  assign gamma_out = gamma_q;
endmodule

// File: tb/tb_soft_gamma.sv
// tb_soft_gamma: random and directed stimulus against an arithmetic gamma model with per-cycle output checking.
module tb_soft_gamma;
  localparam longint ONE = 65536, PD = 21845, PI = 21845, PS = 21845, PT = ONE - PD - PI;
  localparam int DEPTH = 8192;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, b = 1'b0;
  logic [15:0] n_in = '0, t = '0, d = '0, d_tag = '0;
  logic [31:0] r = '0;
  logic out_valid;
  logic [16:0] gamma_out;
  int checks = 0, errors = 0, cyc = 0;
  bit exp_v[0:DEPTH-1];
  longint exp_g[0:DEPTH-1];

  soft_gamma dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .N(n_in), .r(r), .t(t), .d(d),
    .d_tag(d_tag), .b(b), .out_valid(out_valid), .gamma_out(gamma_out)
  );

  always #5 clk = ~clk;

  function automatic longint gref(input logic [15:0] nn, input logic [31:0] rr,
                                  input logic [15:0] tt, input logic [15:0] dd,
                                  input logic [15:0] dt, input logic bb);
    int n, p, m;
    longint e, g;
    n = (int'(nn) > 32) ? 32 : int'(nn);
    p = int'(tt) + int'($signed(dd));
    m = int'($signed(dt)) - int'($signed(dd));
    if (m == -1) return (p >= 0 && p <= n) ? PD : 0;
    if (m < 0 || m > 2 || p < 0 || p + m > n - 1) return 0;
    e = (rr[p+m] == bb) ? ONE - PS : PS;
    g = (PT * e) >> 16;
    for (int k = 0; k < m; k++) g = (g * (PI / 2)) >> 16;
    return (g > ONE) ? ONE : g;
  endfunction

  // a sample taken at one edge is due on the output after the following edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc + 2 < DEPTH) begin
      exp_v[cyc+2] <= rst_n && in_valid;
      exp_g[cyc+2] <= gref(n_in, r, t, d, d_tag, b);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  initial begin
    longint last;
    last = 0;
    chk("pin_match", gref(16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1), 14564);
    chk("pin_mismatch", gref(16'd5, 32'h15, 16'd1, 16'd0, 16'd0, 1'b1), 7281);
    chk("pin_ins1", gref(16'd5, 32'h15, 16'd0, 16'd0, 16'd1, 1'b1), 1213);
    chk("pin_ins2", gref(16'd5, 32'h15, 16'd0, 16'd0, 16'd2, 1'b1), 404);
    chk("pin_del", gref(16'd5, 32'h15, 16'd4, 16'd0, 16'hFFFF, 1'b1), 21845);
    chk("pin_p_eq_n", gref(16'd5, 32'h15, 16'd5, 16'd0, 16'd0, 1'b1), 0);
    chk("pin_delta_m2", gref(16'd5, 32'h15, 16'd30, 16'd5, 16'd3, 1'b1), 0);
    chk("pin_del32_b0", gref(16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd14, 1'b0), 21845);
    chk("pin_del32_b1", gref(16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd14, 1'b1), 21845);
    chk("pin_sub32_b1", gref(16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd15, 1'b1), 14564);
    chk("pin_sub32_b0", gref(16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd15, 1'b0), 7281);
    chk("pin_n0_del", gref(16'd0, 32'h15, 16'd0, 16'd0, 16'hFFFF, 1'b1), 21845);
    chk("pin_n0_sub", gref(16'd0, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1), 0);
    chk("pin_neg_p", gref(16'd5, 32'h15, 16'd0, 16'hFFFF, 16'hFFFE, 1'b1), 0);
    chk("pin_clamp_sub", gref(16'd40, 32'hFFFFFFFF, 16'd31, 16'd0, 16'd0, 1'b1), 14564);
    chk("pin_clamp_del", gref(16'd40, 32'hFFFFFFFF, 16'd32, 16'd0, 16'hFFFF, 1'b1), 21845);
    chk("pin_clamp_oob", gref(16'd40, 32'hFFFFFFFF, 16'd32, 16'd0, 16'd0, 1'b1), 0);
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        last = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_gamma", gamma_out, 0);
      end else begin
        if (exp_v[cyc]) last = exp_g[cyc];
        chk("out_valid", out_valid, exp_v[cyc]);
        chk("gamma_out", gamma_out, last);
      end
    end
  end

  task automatic drv(input logic v, input logic [15:0] nn, input logic [31:0] rr,
                     input logic [15:0] tt, input logic [15:0] dd,
                     input logic [15:0] dt, input logic bb);
    @(negedge clk);
    in_valid = v;
    n_in = nn;
    r = rr;
    t = tt;
    d = dd;
    d_tag = dt;
    b = bb;
  endtask

  initial begin
    logic [15:0] rt, rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drv(1, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd1, 16'd0, 16'd0, 1'b1);
    drv(0, 16'd5, 32'h15, 16'd1, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd0, 16'd0, 16'd1, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd0, 16'd0, 16'd2, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd4, 16'd0, 16'hFFFF, 1'b0);
    drv(1, 16'd5, 32'h15, 16'd5, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd30, 16'd5, 16'd3, 1'b1);
    drv(1, 16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd14, 1'b0);
    drv(1, 16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd14, 1'b1);
    drv(1, 16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd15, 1'b1);
    drv(1, 16'd32, 32'hFFFF0000, 16'd2, 16'd15, 16'd15, 1'b0);
    drv(1, 16'd0, 32'h15, 16'd0, 16'd0, 16'hFFFF, 1'b1);
    drv(1, 16'd0, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd0, 16'hFFFF, 16'hFFFE, 1'b1);
    drv(1, 16'd40, 32'hFFFFFFFF, 16'd31, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd40, 32'hFFFFFFFF, 16'd32, 16'd0, 16'hFFFF, 1'b1);
    drv(1, 16'd40, 32'hFFFFFFFF, 16'd32, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'hFFFFFFF5, 16'd1, 16'd0, 16'd0, 1'b1);
    repeat (3) drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b0);
    drv(1, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd1, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd4, 16'd0, 16'hFFFF, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd0, 16'd0, 16'd1, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd5, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd2, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd3, 16'd0, 16'd0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    drv(1, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b1);
    drv(1, 16'd5, 32'h15, 16'd1, 16'd0, 16'd0, 1'b0);
    drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;
    repeat (3) drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      rt = 16'($urandom_range(0, 36));
      rd = 16'($urandom_range(0, 16)) - 16'd8;
      if ($urandom_range(0, 19) == 0) rt = 16'($urandom);
      if ($urandom_range(0, 19) == 0) rd = 16'($urandom);
      drv($urandom_range(0, 9) < 7,
          ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40)),
          $urandom, rt, rd, rd + 16'($urandom_range(0, 5)) - 16'd2, 1'($urandom));
    end
    repeat (4) drv(0, 16'd5, 32'h15, 16'd0, 16'd0, 16'd0, 1'b0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
